// File: rtl/mii_pkg.sv
// Shared types and constants for the MII receive framer and its CRC helper.
package mii_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    BODY,
    DROP
  } mii_state_e;

  localparam logic [3:0]  SFD_NIBBLE  = 4'hD;
  localparam logic [3:0]  PRE_NIBBLE  = 4'h5;
  localparam int unsigned HDR_BYTES   = 14;
  localparam int unsigned FCS_BYTES   = 4;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam int unsigned ERR_ALIGN    = 0;
  localparam int unsigned ERR_RUNT     = 1;
  localparam int unsigned ERR_OVERSIZE = 2;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mii_crc32_byte.sv
// Combinational one-byte update of a reflected (LSB-first) CRC-32 register.
module mii_crc32_byte
  import mii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data_i[i]) begin
        c = (c >> 1) ^ POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, latches the header, streams payload minus FCS.
// Define MII_RX_CRC_CHECK_EN to check the frame CRC; otherwise frm_crc_ok reports 1.
module mii_rx_framer
  import mii_pkg::*;
#(
  parameter int unsigned MAX_FRAME    = 1518,
  parameter int unsigned MIN_FRAME    = 64,
  parameter int unsigned MIN_PREAMBLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nib_stb,
  input  logic        nib_en,
  input  logic [3:0]  nib_d,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type,
  output logic        hdr_valid,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        frm_done,
  output logic [10:0] frm_len,
  output logic        frm_crc_ok,
  output logic [2:0]  frm_err
);

  localparam logic [10:0] MAX_LEN   = 11'(MAX_FRAME);
  localparam logic [10:0] MIN_LEN   = 11'(MIN_FRAME);
  localparam logic [10:0] HDR_LEN   = 11'(HDR_BYTES);
  localparam logic [3:0]  MIN_PRE   = 4'(MIN_PREAMBLE);
  localparam logic [2:0]  FIFO_FULL = 3'(FCS_BYTES);

  mii_state_e state_q, state_d;
  logic [3:0]  pcnt_q, pcnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        half_q, half_d;
  logic [3:0]  lo_nib_q, lo_nib_d;
  logic [FCS_BYTES-1:0][7:0] fifo_q, fifo_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        sof_pend_q, sof_pend_d;
  logic        oversize_q, oversize_d;
  logic [47:0] dst_q, dst_d;
  logic [47:0] src_q, src_d;
  logic [15:0] type_q, type_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_sof_q, out_sof_d;
  logic        frm_done_q, frm_done_d;
  logic [10:0] frm_len_q, frm_len_d;
  logic        frm_crc_ok_q, frm_crc_ok_d;
  logic [2:0]  frm_err_q, frm_err_d;

  logic [7:0]  byte_w;
  logic [10:0] cnt_inc;
  logic        crc_ok;

  assign byte_w  = {nib_d, lo_nib_q};
  assign cnt_inc = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 11'd1;

`ifdef MII_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_next;

  mii_crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (byte_w),
    .crc_o  (crc_next)
  );

  // The register shifts LSB-first, so compare against the residue in reflected order.
  assign crc_ok = (reflect32(crc_q) == CRC_RESIDUE);
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    byte_cnt_d   = byte_cnt_q;
    half_d       = half_q;
    lo_nib_d     = lo_nib_q;
    fifo_d       = fifo_q;
    fcnt_d       = fcnt_q;
    sof_pend_d   = sof_pend_q;
    oversize_d   = oversize_q;
    dst_d        = dst_q;
    src_d        = src_q;
    type_d       = type_q;
    hdr_valid_d  = hdr_valid_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sof_d    = out_sof_q;
    frm_done_d   = 1'b0;
    frm_len_d    = frm_len_q;
    frm_crc_ok_d = frm_crc_ok_q;
    frm_err_d    = frm_err_q;
`ifdef MII_RX_CRC_CHECK_EN
    crc_d        = crc_q;
`endif

    if (nib_stb) begin
      hdr_valid_d = 1'b0;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;

      unique case (state_q)
        IDLE: begin
          if (nib_en && nib_d == PRE_NIBBLE) begin
            state_d    = PRE;
            pcnt_d     = 4'd1;
            byte_cnt_d = '0;
            half_d     = 1'b0;
            oversize_d = 1'b0;
`ifdef MII_RX_CRC_CHECK_EN
            crc_d      = '1;
`endif
          end
        end

        PRE: begin
          if (!nib_en) begin
            state_d = IDLE;
          end else if (nib_d == PRE_NIBBLE) begin
            if (pcnt_q != 4'hF) pcnt_d = pcnt_q + 4'd1;
          end else if (nib_d == SFD_NIBBLE && pcnt_q >= MIN_PRE) begin
            state_d    = BODY;
            fcnt_d     = '0;
            sof_pend_d = 1'b1;
          end else begin
            state_d = DROP;
          end
        end

        BODY: begin
          if (!nib_en) begin
            state_d = IDLE;
          end else if (!half_q) begin
            lo_nib_d = nib_d;
            half_d   = 1'b1;
          end else begin
            half_d     = 1'b0;
            byte_cnt_d = cnt_inc;
`ifdef MII_RX_CRC_CHECK_EN
            crc_d      = crc_next;
`endif
            if (byte_cnt_q < 11'd6) begin
              dst_d = {dst_q[39:0], byte_w};
            end else if (byte_cnt_q < 11'd12) begin
              src_d = {src_q[39:0], byte_w};
            end else if (byte_cnt_q < HDR_LEN) begin
              type_d      = {type_q[7:0], byte_w};
              hdr_valid_d = (byte_cnt_q == HDR_LEN - 11'd1);
            end else begin
              // Payload runs through a delay line sized to the FCS, so the FCS is never emitted.
              if (fcnt_q == FIFO_FULL) begin
                out_valid_d = 1'b1;
                out_data_d  = fifo_q[FCS_BYTES-1];
                out_sof_d   = sof_pend_q;
                sof_pend_d  = 1'b0;
              end else begin
                fcnt_d = fcnt_q + 3'd1;
              end
              fifo_d = {fifo_q[FCS_BYTES-2:0], byte_w};
            end
            if (cnt_inc == MAX_LEN) begin
              oversize_d = 1'b1;
              state_d    = DROP;
            end
          end
        end

        DROP: begin
          if (!nib_en) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase

      if (!nib_en && (state_q == BODY || state_q == DROP)) begin
        frm_done_d               = 1'b1;
        frm_len_d                = byte_cnt_q;
        frm_crc_ok_d             = crc_ok;
        frm_err_d[ERR_OVERSIZE]  = oversize_q;
        frm_err_d[ERR_RUNT]      = (byte_cnt_q < MIN_LEN);
        frm_err_d[ERR_ALIGN]     = half_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      byte_cnt_q   <= '0;
      half_q       <= 1'b0;
      lo_nib_q     <= '0;
      fifo_q       <= '0;
      fcnt_q       <= '0;
      sof_pend_q   <= 1'b0;
      oversize_q   <= 1'b0;
      dst_q        <= '0;
      src_q        <= '0;
      type_q       <= '0;
      hdr_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sof_q    <= 1'b0;
      frm_done_q   <= 1'b0;
      frm_len_q    <= '0;
      frm_crc_ok_q <= 1'b0;
      frm_err_q    <= '0;
`ifdef MII_RX_CRC_CHECK_EN
      crc_q        <= '1;
`endif
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      byte_cnt_q   <= byte_cnt_d;
      half_q       <= half_d;
      lo_nib_q     <= lo_nib_d;
      fifo_q       <= fifo_d;
      fcnt_q       <= fcnt_d;
      sof_pend_q   <= sof_pend_d;
      oversize_q   <= oversize_d;
      dst_q        <= dst_d;
      src_q        <= src_d;
      type_q       <= type_d;
      hdr_valid_q  <= hdr_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sof_q    <= out_sof_d;
      frm_done_q   <= frm_done_d;
      frm_len_q    <= frm_len_d;
      frm_crc_ok_q <= frm_crc_ok_d;
      frm_err_q    <= frm_err_d;
`ifdef MII_RX_CRC_CHECK_EN
      crc_q        <= crc_d;
`endif
    end
  end

  assign dst_mac    = dst_q;
  assign src_mac    = src_q;
  assign eth_type   = type_q;
  assign hdr_valid  = hdr_valid_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign frm_done   = frm_done_q;
  assign frm_len    = frm_len_q;
  assign frm_crc_ok = frm_crc_ok_q;
  assign frm_err    = frm_err_q;

endmodule

// File: tb/tb_mii_rx_framer.sv
// Randomized bench for mii_rx_framer against a frame-level reference model.
module tb_mii_rx_framer;

  localparam int MAX_FRAME = 1518;
  localparam int MIN_FRAME = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        nib_stb;
  logic        nib_en;
  logic [3:0]  nib_d;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic        hdr_valid;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        frm_done;
  logic [10:0] frm_len;
  logic        frm_crc_ok;
  logic [2:0]  frm_err;

  always #5 clk = ~clk;

  mii_rx_framer #(
    .MAX_FRAME    (MAX_FRAME),
    .MIN_FRAME    (MIN_FRAME),
    .MIN_PREAMBLE (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .nib_stb    (nib_stb),
    .nib_en     (nib_en),
    .nib_d      (nib_d),
    .dst_mac    (dst_mac),
    .src_mac    (src_mac),
    .eth_type   (eth_type),
    .hdr_valid  (hdr_valid),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .frm_done   (frm_done),
    .frm_len    (frm_len),
    .frm_crc_ok (frm_crc_ok),
    .frm_err    (frm_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int gap_max  = 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] typ;
  } hdr_t;

  typedef struct packed {
    logic [10:0] len;
    logic        ok;
    logic [2:0]  err;
  } st_t;

  logic [7:0] frm[$];
  hdr_t       hq[$];
  logic [7:0] pq[$];
  logic       sq[$];
  st_t        stq[$];

  // Observed events: header/payload strobes after each nibble strobe, status pulses every cycle.
  always @(posedge clk) begin : mon
    bit s;
    s = nib_stb;
    #1;
    if (frm_done) stq.push_back(st_t'{frm_len, frm_crc_ok, frm_err});
    if (s) begin
      if (hdr_valid) hq.push_back(hdr_t'{dst_mac, src_mac, eth_type});
      if (out_valid) begin
        pq.push_back(out_data);
        sq.push_back(out_sof);
      end
    end
  end

  function automatic logic [31:0] crc32_of(input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_frame(input int len, input bit good_fcs, input bit fixed_hdr);
    logic [111:0] hdr;
    logic [31:0]  c;
    hdr = 112'h54ff01212324_123456789abc_1234;
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    if (fixed_hdr && len >= 14)
      for (int i = 0; i < 14; i++) frm[i] = hdr[111-8*i -: 8];
    if (good_fcs && len >= 4) begin
      c = crc32_of(len - 4);
      for (int i = 0; i < 4; i++) frm[len-4+i] = c[8*i +: 8];
    end
  endtask

  task automatic idle(input int n);
    nib_stb = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic [3:0] d);
    int g;
    nib_stb = 1'b1;
    nib_en  = en;
    nib_d   = d;
    @(negedge clk);
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    if (g > 0) begin
      nib_stb = 1'b0;
      nib_en  = 1'($urandom);
      nib_d   = 4'($urandom);
      repeat (g) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int npre, input bit bad_pre, input bit odd);
    for (int i = 0; i < npre; i++) drive(1'b1, 4'h5);
    if (bad_pre) begin
      drive(1'b1, 4'h7);
      for (int i = 0; i < 6; i++) drive(1'b1, 4'($urandom));
    end else begin
      drive(1'b1, 4'hD);
      for (int i = 0; i < frm.size(); i++) begin
        drive(1'b1, frm[i][3:0]);
        drive(1'b1, frm[i][7:4]);
      end
      if (odd) drive(1'b1, 4'($urandom));
    end
    drive(1'b0, 4'($urandom));
    idle(3);
  endtask

  task automatic check_frame(input bit pre_ok, input bit odd, input bit aborted);
    int          n;
    int          exp_pay;
    bit          ovs;
    bit          ok;
    logic [47:0] ed;
    logic [47:0] es;
    logic [15:0] et;
    logic [31:0] fcs;
    idle(2);
    n   = pre_ok ? frm.size() : 0;
    ovs = (n >= MAX_FRAME);
    if (ovs) n = MAX_FRAME;
    check_eq("hdr_count", 64'(hq.size()), 64'(n >= 14));
    if (n >= 14 && hq.size() > 0) begin
      ed = '0; es = '0; et = '0;
      for (int i = 0; i < 6; i++) ed = {ed[39:0], frm[i]};
      for (int i = 6; i < 12; i++) es = {es[39:0], frm[i]};
      et = {frm[12], frm[13]};
      check_eq("dst_mac", hq[0].dst, ed);
      check_eq("src_mac", hq[0].src, es);
      check_eq("eth_type", hq[0].typ, et);
    end
    exp_pay = (n >= 18) ? n - 18 : 0;
    check_eq("payload_count", 64'(pq.size()), 64'(exp_pay));
    for (int i = 0; i < pq.size() && i < exp_pay; i++) begin
      check_eq("payload_byte", pq[i], frm[14+i]);
      check_eq("payload_sof", sq[i], 64'(i == 0));
    end
    check_eq("status_count", 64'(stq.size()), aborted ? 0 : 1);
    if (!aborted && stq.size() > 0) begin
`ifdef MII_RX_CRC_CHECK_EN
      fcs = '0;
      if (n >= 4) fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
      ok  = (n >= 4) && (crc32_of(n - 4) == fcs);
`else
      fcs = '0;
      ok  = 1'b1;
`endif
      check_eq("frm_len", stq[0].len, 64'(n));
      check_eq("frm_err", stq[0].err, {61'b0, ovs, n < MIN_FRAME, odd && pre_ok && !ovs});
      check_eq("frm_crc_ok", stq[0].ok, 64'(ok));
    end
    hq.delete();
    pq.delete();
    sq.delete();
    stq.delete();
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_dst"}, dst_mac, 0);
    check_eq({tag, "_src"}, src_mac, 0);
    check_eq({tag, "_type"}, eth_type, 0);
    check_eq({tag, "_hdr_valid"}, hdr_valid, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
    check_eq({tag, "_out_sof"}, out_sof, 0);
    check_eq({tag, "_frm_done"}, frm_done, 0);
    check_eq({tag, "_frm_len"}, frm_len, 0);
    check_eq({tag, "_frm_crc_ok"}, frm_crc_ok, 0);
    check_eq({tag, "_frm_err"}, frm_err, 0);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  len;
    int  npre;
    bit  bad;
    bit  odd;
    bit  good;

    rst     = 1'b1;
    nib_stb = 1'b0;
    nib_en  = 1'b0;
    nib_d   = 4'h0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    idle(2);

    // Header/payload reference frame, runt because it is only 50 bytes
    make_frame(50, 1'b1, 1'b1);
    send_frame(15, 1'b0, 1'b0);
    check_frame(1'b1, 1'b0, 1'b0);

    // Minimum-size frame with good FCS, then the same frame with one payload bit flipped
    make_frame(64, 1'b1, 1'b1);
    send_frame(15, 1'b0, 1'b0);
    check_frame(1'b1, 1'b0, 1'b0);
    frm[20] ^= 8'h04;
    send_frame(15, 1'b0, 1'b0);
    check_frame(1'b1, 1'b0, 1'b0);

    // Broken preamble: status with zero length only
    make_frame(30, 1'b1, 1'b0);
    send_frame(2, 1'b1, 1'b0);
    check_frame(1'b0, 1'b0, 1'b0);

    // Trailing half byte
    make_frame(40, 1'b1, 1'b0);
    send_frame(7, 1'b0, 1'b1);
    check_frame(1'b1, 1'b1, 1'b0);

    // Oversize frame, back-to-back strobes
    gap_max = 0;
    make_frame(1600, 1'b0, 1'b0);
    send_frame(8, 1'b0, 1'b0);
    check_frame(1'b1, 1'b0, 1'b0);
    gap_max = 1;

    // Reset during payload byte 10, then a clean 64-byte frame
    make_frame(64, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, frm[i][3:0]);
      drive(1'b1, frm[i][7:4]);
    end
    drive(1'b1, frm[24][3:0]);
    nib_stb = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_cleared("midreset");
    @(negedge clk);
    rst = 1'b0;
    while (frm.size() > 24) void'(frm.pop_back());
    check_frame(1'b1, 1'b0, 1'b1);
    make_frame(64, 1'b1, 1'b1);
    send_frame(4, 1'b0, 1'b0);
    check_frame(1'b1, 1'b0, 1'b0);

    // Random frames
    repeat (30) begin
      len  = int'($urandom_range(0, 100));
      npre = int'($urandom_range(1, 20));
      bad  = ($urandom_range(0, 7) == 0);
      odd  = 1'($urandom_range(0, 1));
      good = ($urandom_range(0, 3) != 0);
      gap_max = int'($urandom_range(0, 2));
      make_frame(len, good, 1'b0);
      send_frame(npre, bad, odd);
      check_frame(!bad, odd && !bad, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
